// File: rtl/vga_pixel_colproc_if.sv
// Pixel-path bus bundle: video-memory write side, RGB buffer push side and CLUT read side.
// slave = the pixel pipeline, master = the surrounding WISHBONE master / RGB buffer / CLUT.
interface vga_pixel_colproc_if;
  logic [31:0] pix_d;
  logic        pix_wreq;
  logic        pix_hfull;
  logic        pix_empty;
  logic        RGB_fifo_full;
  logic        RGB_fifo_wreq;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  B;
  logic        clut_req;
  logic [7:0]  clut_offs;
  logic        clut_ack;
  logic [31:0] wb_di;

  modport slave (
    input  pix_d, pix_wreq, RGB_fifo_full, clut_ack, wb_di,
    output pix_hfull, pix_empty, RGB_fifo_wreq, R, G, B, clut_req, clut_offs
  );

  modport master (
    output pix_d, pix_wreq, RGB_fifo_full, clut_ack, wb_di,
    input  pix_hfull, pix_empty, RGB_fifo_wreq, R, G, B, clut_req, clut_offs
  );
endinterface

// File: rtl/vga_pixel_colproc.sv
// Pixel word FIFO plus colour processor unpacking 8/16/24/32 bpp words into registered RGB pixels.
// Latency: word write -> first pixel pulse 3 edges (flag, IDLE->PROC, emit); CLUT adds request/ack round trip.
// Backpressure: no pixel is emitted while RGB_fifo_full is high; words stay in the FIFO until fully consumed.
module vga_pixel_colproc #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic               CLK_I,
  input  logic               nRESET,
  input  logic               srst,
  input  logic [1:0]         ColorDepth,
  input  logic               PseudoColor,
  vga_pixel_colproc_if.slave bus
);

  localparam int          DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0] HALF  = (AW + 1)'(DEPTH / 2);

  typedef enum logic [1:0] {IDLE, PROC, CLUT} state_t;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_nxt;
  logic          empty_r, hfull_r;
  logic          wr_en, rd_en, pop;

  state_t        state;
  logic [1:0]    phase, phase_nxt;
  logic [15:0]   left;
  logic [23:0]   clut_dat;
  logic          clut_have;
  logic [31:0]   head;
  logic [7:0]    byte_sel;
  logic [15:0]   half;
  logic [23:0]   pix;
  logic          last, clut_mode, direct_emit, clut_emit;

  assign wr_en         = bus.pix_wreq && (count != FULL) && !srst;
  assign rd_en         = pop && !empty_r;
  assign head          = mem[rptr];
  assign bus.pix_empty = empty_r;
  assign bus.pix_hfull = hfull_r;

  always_comb begin
    count_nxt = count;
    if (wr_en && !rd_en)
      count_nxt = count + 1'b1;
    else if (!wr_en && rd_en)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge CLK_I) begin
    if (wr_en)
      mem[wptr] <= bus.pix_d;
  end

  always_ff @(posedge CLK_I or negedge nRESET) begin
    if (!nRESET) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      empty_r <= 1'b1;
      hfull_r <= 1'b0;
    end else if (srst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      empty_r <= 1'b1;
      hfull_r <= 1'b0;
    end else begin
      if (wr_en)
        wptr <= wptr + 1'b1;
      if (rd_en)
        rptr <= rptr + 1'b1;
      count   <= count_nxt;
      empty_r <= (count_nxt == '0);
      hfull_r <= (count_nxt >= HALF);
    end
  end

  // Pixel selection for the current phase; 24bpp splices leftover bits of the previous word.
  always_comb begin
    case (phase)
      2'd0:    byte_sel = head[31:24];
      2'd1:    byte_sel = head[23:16];
      2'd2:    byte_sel = head[15:8];
      default: byte_sel = head[7:0];
    endcase
    half      = phase[0] ? head[15:0] : head[31:16];
    pix       = head[23:0];
    last      = 1'b1;
    phase_nxt = 2'd0;
    case (ColorDepth)
      2'b00: begin
        pix       = {3{byte_sel}};
        last      = (phase == 2'd3);
        phase_nxt = phase + 2'd1;
      end
      2'b01: begin
        pix       = {half[15:11], 3'b000, half[10:5], 2'b00, half[4:0], 3'b000};
        last      = phase[0];
        phase_nxt = {1'b0, ~phase[0]};
      end
      2'b10: begin
        case (phase)
          2'd0:    pix = head[31:8];
          2'd1:    pix = {left[7:0], head[31:16]};
          2'd2:    pix = {left[15:0], head[31:24]};
          default: pix = head[23:0];
        endcase
        last      = (phase != 2'd2);
        phase_nxt = phase + 2'd1;
      end
      default: ;
    endcase
    clut_mode   = (ColorDepth == 2'b00) && PseudoColor;
    direct_emit = (state == PROC) && !empty_r && !bus.RGB_fifo_full && !clut_mode;
    clut_emit   = (state == CLUT) && clut_have && !bus.RGB_fifo_full;
    pop         = (direct_emit || clut_emit) && last;
  end

  always_ff @(posedge CLK_I or negedge nRESET) begin
    if (!nRESET) begin
      state             <= IDLE;
      phase             <= 2'd0;
      left              <= '0;
      clut_dat          <= '0;
      clut_have         <= 1'b0;
      bus.RGB_fifo_wreq <= 1'b0;
      bus.R             <= '0;
      bus.G             <= '0;
      bus.B             <= '0;
      bus.clut_req      <= 1'b0;
      bus.clut_offs     <= '0;
    end else if (srst) begin
      state             <= IDLE;
      phase             <= 2'd0;
      left              <= '0;
      clut_dat          <= '0;
      clut_have         <= 1'b0;
      bus.RGB_fifo_wreq <= 1'b0;
      bus.R             <= '0;
      bus.G             <= '0;
      bus.B             <= '0;
      bus.clut_req      <= 1'b0;
      bus.clut_offs     <= '0;
    end else begin
      bus.RGB_fifo_wreq <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty_r)
            state <= PROC;
        end
        PROC: begin
          if (empty_r) begin
            state <= IDLE;
          end else if (clut_mode) begin
            bus.clut_req  <= 1'b1;
            bus.clut_offs <= byte_sel;
            state         <= CLUT;
          end else if (direct_emit) begin
            bus.RGB_fifo_wreq         <= 1'b1;
            {bus.R, bus.G, bus.B}     <= pix;
            phase                     <= phase_nxt;
            if (ColorDepth == 2'b10)
              left <= (phase == 2'd0) ? {8'h00, head[7:0]} : head[15:0];
          end
        end
        CLUT: begin
          if (!clut_have) begin
            if (bus.clut_ack) begin
              bus.clut_req <= 1'b0;
              clut_dat     <= bus.wb_di[23:0];
              clut_have    <= 1'b1;
            end
          end else if (clut_emit) begin
            bus.RGB_fifo_wreq     <= 1'b1;
            {bus.R, bus.G, bus.B} <= clut_dat;
            clut_have             <= 1'b0;
            phase                 <= phase_nxt;
            state                 <= PROC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pixel_colproc.sv
// Directed bench for vga_pixel_colproc: each colour mode, backpressure, CLUT handshake, FIFO flags and srst.
// Emitted pixels are collected by a monitor into a queue and compared against hand-computed values.
module tb_vga_pixel_colproc;

  logic       CLK_I;
  logic       nRESET;
  logic       srst;
  logic [1:0] ColorDepth;
  logic       PseudoColor;

  vga_pixel_colproc_if bus ();

  vga_pixel_colproc #(.AW(4), .DW(32)) dut (
    .CLK_I      (CLK_I),
    .nRESET     (nRESET),
    .srst       (srst),
    .ColorDepth (ColorDepth),
    .PseudoColor(PseudoColor),
    .bus        (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] q[$];
  logic [31:0] clut_tab[4] = '{32'h00ABCDEF, 32'h00112233, 32'h00445566, 32'h00778899};

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  always @(negedge CLK_I) begin
    if (bus.RGB_fifo_wreq === 1'b1)
      q.push_back({bus.R, bus.G, bus.B});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK_I);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    bus.pix_d    = d;
    bus.pix_wreq = 1'b1;
    tick();
    bus.pix_wreq = 1'b0;
  endtask

  task automatic do_srst(input logic [1:0] cd, input logic pc);
    ColorDepth  = cd;
    PseudoColor = pc;
    srst        = 1'b1;
    tick();
    srst = 1'b0;
    q.delete();
  endtask

  task automatic wait_pix(input int n, input int budget);
    for (int i = 0; i < budget && q.size() < n; i++)
      tick();
    repeat (6) tick();
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget && bus.clut_req !== 1'b1; i++)
      tick();
  endtask

  initial begin
    nRESET            = 1'b0;
    srst              = 1'b0;
    ColorDepth        = 2'b11;
    PseudoColor       = 1'b0;
    bus.pix_d         = '0;
    bus.pix_wreq      = 1'b0;
    bus.RGB_fifo_full = 1'b0;
    bus.clut_ack      = 1'b0;
    bus.wb_di         = '0;
    tick();
    tick();

    chk("rst_empty", 32'(bus.pix_empty), 32'd1);
    chk("rst_hfull", 32'(bus.pix_hfull), 32'd0);
    chk("rst_wreq", 32'(bus.RGB_fifo_wreq), 32'd0);
    chk("rst_rgb", {8'h00, bus.R, bus.G, bus.B}, 32'h0);
    chk("rst_clut_req", 32'(bus.clut_req), 32'd0);
    chk("rst_clut_offs", 32'(bus.clut_offs), 32'd0);
    nRESET = 1'b1;
    tick();

    // 32bpp: one pixel per word, top byte ignored
    do_srst(2'b11, 1'b0);
    wr(32'h00112233);
    wait_pix(1, 20);
    chk("p32_npix", 32'(q.size()), 32'd1);
    chk("p32_pix", 32'(q[0]), 32'h00112233);
    chk("p32_empty", 32'(bus.pix_empty), 32'd1);

    // 8bpp greyscale, MSB byte first
    do_srst(2'b00, 1'b0);
    wr(32'h10203040);
    wait_pix(4, 30);
    chk("g8_npix", 32'(q.size()), 32'd4);
    chk("g8_pix0", 32'(q[0]), 32'h00101010);
    chk("g8_pix1", 32'(q[1]), 32'h00202020);
    chk("g8_pix2", 32'(q[2]), 32'h00303030);
    chk("g8_pix3", 32'(q[3]), 32'h00404040);

    // 16bpp RGB565 with downstream held full for 3 cycles
    do_srst(2'b01, 1'b0);
    bus.RGB_fifo_full = 1'b1;
    wr(32'hF80007E0);
    repeat (3) tick();
    chk("p16_hold_npix", 32'(q.size()), 32'd0);
    chk("p16_hold_empty", 32'(bus.pix_empty), 32'd0);
    bus.RGB_fifo_full = 1'b0;
    wait_pix(2, 20);
    chk("p16_npix", 32'(q.size()), 32'd2);
    chk("p16_pix0", 32'(q[0]), 32'h00F80000);
    chk("p16_pix1", 32'(q[1]), 32'h0000FC00);

    // 24bpp: three words carry four pixels
    do_srst(2'b10, 1'b0);
    wr(32'hAABBCC11);
    wr(32'h22334455);
    wr(32'h66778899);
    wait_pix(4, 30);
    chk("p24_npix", 32'(q.size()), 32'd4);
    chk("p24_pix0", 32'(q[0]), 32'h00AABBCC);
    chk("p24_pix1", 32'(q[1]), 32'h00112233);
    chk("p24_pix2", 32'(q[2]), 32'h00445566);
    chk("p24_pix3", 32'(q[3]), 32'h00778899);
    chk("p24_empty", 32'(bus.pix_empty), 32'd1);

    // 8bpp CLUT pseudo-colour: four lookups, offsets are the bytes MSB first
    do_srst(2'b00, 1'b1);
    wr(32'h05060708);
    for (int k = 0; k < 4; k++) begin
      wait_req(40);
      chk("clut_req", 32'(bus.clut_req), 32'd1);
      chk("clut_offs", 32'(bus.clut_offs), 32'(5 + k));
      bus.clut_ack = 1'b1;
      bus.wb_di    = clut_tab[k];
      tick();
      bus.clut_ack = 1'b0;
      bus.wb_di    = '0;
      chk("clut_drop", 32'(bus.clut_req), 32'd0);
    end
    wait_pix(4, 20);
    chk("clut_npix", 32'(q.size()), 32'd4);
    chk("clut_pix0", 32'(q[0]), 32'h00ABCDEF);
    chk("clut_pix3", 32'(q[3]), 32'h00778899);
    chk("clut_empty", 32'(bus.pix_empty), 32'd1);

    // FIFO flags: half-full at 8 words, writes beyond 16 ignored
    do_srst(2'b11, 1'b0);
    bus.RGB_fifo_full = 1'b1;
    for (int i = 0; i < 7; i++)
      wr(32'h00A00000 + 32'(i));
    chk("hf_7", 32'(bus.pix_hfull), 32'd0);
    wr(32'h00A00007);
    chk("hf_8", 32'(bus.pix_hfull), 32'd1);
    for (int i = 8; i < 18; i++)
      wr(32'h00A00000 + 32'(i));
    chk("full_empty", 32'(bus.pix_empty), 32'd0);
    bus.RGB_fifo_full = 1'b0;
    wait_pix(16, 100);
    chk("full_npix", 32'(q.size()), 32'd16);
    chk("full_first", 32'(q[0]), 32'h00A00000);
    chk("full_last", 32'(q[15]), 32'h00A0000F);
    chk("full_drained", 32'(bus.pix_empty), 32'd1);

    // srst with a word pending and non-zero colour outputs
    bus.RGB_fifo_full = 1'b1;
    wr(32'h00123456);
    tick();
    chk("srst_pre_empty", 32'(bus.pix_empty), 32'd0);
    do_srst(2'b11, 1'b0);
    chk("srst_empty", 32'(bus.pix_empty), 32'd1);
    chk("srst_hfull", 32'(bus.pix_hfull), 32'd0);
    chk("srst_rgb", {8'h00, bus.R, bus.G, bus.B}, 32'h0);
    chk("srst_wreq", 32'(bus.RGB_fifo_wreq), 32'd0);
    bus.RGB_fifo_full = 1'b0;
    repeat (6) tick();
    chk("srst_npix", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
